// File: rtl/spatz_vrf_wbuf.sv
// spatz_vrf_wbuf
//   Write-back staging buffer between the slide unit's VRF write port and
//   the VRF write arbiter. It is a circular FIFO of Depth write words. The
//   vrf_* outputs always show the head entry.
//
//   A write to the same word address as the newest entry is merged into
//   that entry. The write is byte-masked and the byte enables are ORed. The
//   head entry is never a merge target, so the head stays stable while the
//   VRF stalls.
//
//   drained_o tells the unit that every accepted write has landed.
//
// Ports
//   clk_i, rst_i                    clock, async active-high reset
//   in_waddr_i/wdata_i/wbe_i/we_i   write request from slide unit
//   in_wvalid_o                     request accepted this cycle (comb.)
//   vrf_waddr_o/wdata_o/wbe_o/we_o  head entry offered to the VRF
//   vrf_wvalid_i                    VRF took the head entry this cycle
//   occupancy_o                     number of valid entries
//   drained_o                       empty and no incoming request
module spatz_vrf_wbuf #(
   parameter int Depth     = 4,
   parameter int AddrWidth = 10,
   parameter int DataWidth = 128,
   localparam int BeWidth  = DataWidth / 8,
   localparam int CntW     = $clog2(Depth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [AddrWidth-1:0] in_waddr_i,
   input  logic [DataWidth-1:0] in_wdata_i,
   input  logic [BeWidth-1:0]   in_wbe_i,
   input  logic                 in_we_i,
   output logic                 in_wvalid_o,
   output logic [AddrWidth-1:0] vrf_waddr_o,
   output logic [DataWidth-1:0] vrf_wdata_o,
   output logic [BeWidth-1:0]   vrf_wbe_o,
   output logic                 vrf_we_o,
   input  logic                 vrf_wvalid_i,
   output logic [CntW-1:0]      occupancy_o,
   output logic                 drained_o
);

   localparam int PtrW = $clog2(Depth);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
   localparam logic [CntW-1:0] TwoCnt   = CntW'(2);

   logic [AddrWidth-1:0] mem_addr_q [Depth];
   logic [AddrWidth-1:0] mem_addr_d [Depth];
   logic [DataWidth-1:0] mem_data_q [Depth];
   logic [DataWidth-1:0] mem_data_d [Depth];
   logic [BeWidth-1:0]   mem_be_q   [Depth];
   logic [BeWidth-1:0]   mem_be_d   [Depth];
   logic [PtrW-1:0]      head_q, head_d;
   logic [PtrW-1:0]      tail_q, tail_d;
   logic [CntW-1:0]      count_q, count_d;

   logic [PtrW-1:0] newest;
   logic            zero_be;
   logic            merge;
   logic            push;
   logic            pop;

   always_comb begin
      newest  = tail_q - PtrW'(1);
      zero_be = (in_wbe_i == '0);
      pop     = (count_q != '0) & vrf_wvalid_i;
      // count >= 2 guarantees the newest entry is not the head.
      merge   = in_we_i & ~zero_be & (count_q >= TwoCnt) &
                (mem_addr_q[newest] == in_waddr_i);
      push    = in_we_i & ~zero_be & ~merge & ((count_q < DepthCnt) | pop);
      in_wvalid_o = in_we_i & (merge | zero_be | (count_q < DepthCnt) | pop);
   end

   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_be_d   = mem_be_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;

      if (merge) begin
         for (int b = 0; b < BeWidth; b++) begin
            if (in_wbe_i[b]) begin
               mem_data_d[newest][b*8 +: 8] = in_wdata_i[b*8 +: 8];
            end
         end
         mem_be_d[newest] = mem_be_q[newest] | in_wbe_i;
      end

      // When full with a pop, tail == head; the slot is overwritten at the
      // same edge the old head leaves, so the offered word is unaffected.
      if (push) begin
         mem_addr_d[tail_q] = in_waddr_i;
         mem_data_d[tail_q] = in_wdata_i;
         mem_be_d[tail_q]   = in_wbe_i;
         tail_d             = tail_q + PtrW'(1);
      end

      if (pop) begin
         head_d = head_q + PtrW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) begin
            mem_addr_q[i] <= '0;
            mem_data_q[i] <= '0;
            mem_be_q[i]   <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_be_q   <= mem_be_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   assign vrf_waddr_o = mem_addr_q[head_q];
   assign vrf_wdata_o = mem_data_q[head_q];
   assign vrf_wbe_o   = mem_be_q[head_q];
   assign vrf_we_o    = (count_q != '0);
   assign occupancy_o = count_q;
   assign drained_o   = (count_q == '0) & ~in_we_i;

endmodule

// File: tb/tb_spatz_vrf_wbuf.sv
module tb_spatz_vrf_wbuf;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [9:0]   in_waddr = '0;
   logic [127:0] in_wdata = '0;
   logic [15:0]  in_wbe = '0;
   logic         in_we = 1'b0;
   logic         in_wvalid_o;
   logic [9:0]   vrf_waddr_o;
   logic [127:0] vrf_wdata_o;
   logic [15:0]  vrf_wbe_o;
   logic         vrf_we_o;
   logic         vrf_wvalid = 1'b0;
   logic [2:0]   occupancy_o;
   logic         drained_o;

   spatz_vrf_wbuf dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_waddr_i   (in_waddr),
      .in_wdata_i   (in_wdata),
      .in_wbe_i     (in_wbe),
      .in_we_i      (in_we),
      .in_wvalid_o  (in_wvalid_o),
      .vrf_waddr_o  (vrf_waddr_o),
      .vrf_wdata_o  (vrf_wdata_o),
      .vrf_wbe_o    (vrf_wbe_o),
      .vrf_we_o     (vrf_we_o),
      .vrf_wvalid_i (vrf_wvalid),
      .occupancy_o  (occupancy_o),
      .drained_o    (drained_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]   addr;
      logic [127:0] data;
      logic [15:0]  be;
   } ent_t;

   typedef struct {
      logic       we;
      logic [9:0] addr;
      logic [15:0] be;
      logic       rdy;
      logic       exp_ack;
      int         exp_occ;
   } vec_t;

   ent_t mq[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic ack;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, check combinational outputs
   // and the head entry against the reference queue, then advance the queue
   // at the rising edge and check occupancy.
   task automatic step(input logic we, input logic [9:0] a, input logic [15:0] be,
                       input logic rdy, output logic ack_o);
      logic [127:0] d;
      bit zb, mrg, pp, ack_exp;
      ent_t e;
      @(negedge clk);
      d = {$urandom, $urandom, $urandom, $urandom};
      in_we = we; in_waddr = a; in_wdata = d; in_wbe = be; vrf_wvalid = rdy;
      #1;
      zb  = (be == 16'h0);
      mrg = we && !zb && mq.size() >= 2 && mq[mq.size()-1].addr == a;
      pp  = mq.size() != 0 && rdy;
      ack_exp = we && (mrg || zb || mq.size() < 4 || pp);
      chk("in_wvalid", {127'b0, in_wvalid_o}, {127'b0, ack_exp});
      chk("drained", {127'b0, drained_o}, {127'b0, (mq.size() == 0) && !we});
      if (mq.size() != 0) begin
         chk("vrf_we", {127'b0, vrf_we_o}, 128'd1);
         chk("vrf_waddr", {118'b0, vrf_waddr_o}, {118'b0, mq[0].addr});
         chk("vrf_wdata", vrf_wdata_o, mq[0].data);
         chk("vrf_wbe", {112'b0, vrf_wbe_o}, {112'b0, mq[0].be});
      end else begin
         chk("vrf_we_idle", {127'b0, vrf_we_o}, 128'd0);
      end
      ack_o = in_wvalid_o;
      @(posedge clk);
      if (mrg) begin
         e = mq[mq.size()-1];
         for (int b = 0; b < 16; b++)
            if (be[b]) e.data[b*8 +: 8] = d[b*8 +: 8];
         e.be = e.be | be;
         mq[mq.size()-1] = e;
      end
      if (pp) void'(mq.pop_front());
      if (we && !zb && !mrg && ack_exp) mq.push_back('{a, d, be});
      #1;
      chk("occupancy", {125'b0, occupancy_o}, 128'(mq.size()));
   endtask

   function automatic vec_t v(input logic we, input logic [9:0] a, input logic [15:0] be,
                              input logic rdy, input logic ea, input int eo);
      vec_t r;
      r.we = we; r.addr = a; r.be = be; r.rdy = rdy; r.exp_ack = ea; r.exp_occ = eo;
      return r;
   endfunction

   initial begin
      // single write
      tbl.push_back(v(1, 10'h10, 16'hFFFF, 1, 1, 1));
      tbl.push_back(v(0, 10'h00, 16'h0000, 1, 0, 0));
      tbl.push_back(v(0, 10'h00, 16'h0000, 1, 0, 0));
      // fill, full reject, pop+push at full, merge at full, drain
      tbl.push_back(v(1, 10'h40, 16'hFFFF, 0, 1, 1));
      tbl.push_back(v(1, 10'h41, 16'hFFFF, 0, 1, 2));
      tbl.push_back(v(1, 10'h42, 16'hFFFF, 0, 1, 3));
      tbl.push_back(v(1, 10'h43, 16'hFFFF, 0, 1, 4));
      tbl.push_back(v(1, 10'h44, 16'hFFFF, 0, 0, 4));
      tbl.push_back(v(1, 10'h44, 16'hFFFF, 1, 1, 4));
      tbl.push_back(v(1, 10'h44, 16'h00F0, 0, 1, 4));
      tbl.push_back(v(0, 10'h00, 16'h0000, 1, 0, 3));
      tbl.push_back(v(0, 10'h00, 16'h0000, 1, 0, 2));
      tbl.push_back(v(0, 10'h00, 16'h0000, 1, 0, 1));
      tbl.push_back(v(0, 10'h00, 16'h0000, 1, 0, 0));
      // zero byte enables, and no merge into a lone head entry
      tbl.push_back(v(1, 10'h50, 16'h0000, 0, 1, 0));
      tbl.push_back(v(1, 10'h51, 16'hFFFF, 0, 1, 1));
      tbl.push_back(v(1, 10'h51, 16'h0000, 0, 1, 1));
      tbl.push_back(v(1, 10'h51, 16'h00FF, 0, 1, 2));
      tbl.push_back(v(0, 10'h00, 16'h0000, 1, 0, 1));
      tbl.push_back(v(0, 10'h00, 16'h0000, 1, 0, 0));

      #2;
      chk("rst_vrf_we", {127'b0, vrf_we_o}, 128'd0);
      chk("rst_waddr", {118'b0, vrf_waddr_o}, 128'd0);
      chk("rst_wbe", {112'b0, vrf_wbe_o}, 128'd0);
      chk("rst_occ", {125'b0, occupancy_o}, 128'd0);
      chk("rst_drained", {127'b0, drained_o}, 128'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].rdy, ack);
         chk($sformatf("tbl_ack[%0d]", i), {127'b0, ack}, {127'b0, tbl[i].exp_ack});
         chk($sformatf("tbl_occ[%0d]", i), {125'b0, occupancy_o}, 128'(tbl[i].exp_occ));
      end

      // merge behind the head
      step(1, 10'h20, 16'h000F, 0, ack);
      step(1, 10'h21, 16'h000F, 0, ack);
      step(1, 10'h21, 16'hF000, 0, ack);
      chk("merge_occ", {125'b0, occupancy_o}, 128'd2);
      step(0, 10'h00, 16'h0000, 1, ack);
      chk("merge_addr", {118'b0, vrf_waddr_o}, 128'h21);
      chk("merge_be", {112'b0, vrf_wbe_o}, 128'hF00F);
      step(0, 10'h00, 16'h0000, 1, ack);

      // same address with a single entry: two writes, head held while stalled
      step(1, 10'h30, 16'h00FF, 0, ack);
      step(1, 10'h30, 16'hFF00, 0, ack);
      chk("nohead_occ", {125'b0, occupancy_o}, 128'd2);
      for (int i = 0; i < 2; i++) begin
         step(0, 10'h00, 16'h0000, 0, ack);
         chk("stall_addr", {118'b0, vrf_waddr_o}, 128'h30);
         chk("stall_be", {112'b0, vrf_wbe_o}, 128'h00FF);
      end
      step(0, 10'h00, 16'h0000, 1, ack);
      chk("second_be", {112'b0, vrf_wbe_o}, 128'hFF00);
      step(0, 10'h00, 16'h0000, 1, ack);

      // merge and pop in the same cycle
      step(1, 10'h60, 16'h000F, 0, ack);
      step(1, 10'h61, 16'h000F, 0, ack);
      step(1, 10'h61, 16'h0F00, 1, ack);
      chk("mergepop_occ", {125'b0, occupancy_o}, 128'd1);
      chk("mergepop_be", {112'b0, vrf_wbe_o}, 128'h0F0F);
      step(0, 10'h00, 16'h0000, 1, ack);

      // asynchronous reset with writes queued
      step(1, 10'h70, 16'hFFFF, 0, ack);
      step(1, 10'h71, 16'hFFFF, 0, ack);
      step(1, 10'h72, 16'hFFFF, 0, ack);
      chk("prerst_occ", {125'b0, occupancy_o}, 128'd3);
      @(negedge clk);
      in_we = 1'b0; in_wbe = '0;
      vrf_wvalid = 1'b1;
      #2 vrf_wvalid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("arst_vrf_we", {127'b0, vrf_we_o}, 128'd0);
      chk("arst_occ", {125'b0, occupancy_o}, 128'd0);
      chk("arst_waddr", {118'b0, vrf_waddr_o}, 128'd0);
      chk("arst_drained", {127'b0, drained_o}, 128'd1);
      mq.delete();
      @(posedge clk);
      vrf_wvalid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 10'h00, 16'h0000, i[0], ack);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
